// File: rtl/id_control_stage_pkg.sv
// Shared definitions for the ID control stage: opcodes, ALU/immediate codes,
// FSM states and the ID/EX control bundle.
package id_control_stage_pkg;

  localparam int unsigned ALUOP_W = 5;
  localparam int unsigned IMM_W   = 3;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] ALU_MUL  = ALUOP_W'(10);

  localparam logic [IMM_W-1:0] IMM_NONE = IMM_W'(0);
  localparam logic [IMM_W-1:0] IMM_I    = IMM_W'(1);
  localparam logic [IMM_W-1:0] IMM_S    = IMM_W'(2);
  localparam logic [IMM_W-1:0] IMM_B    = IMM_W'(3);
  localparam logic [IMM_W-1:0] IMM_U    = IMM_W'(4);
  localparam logic [IMM_W-1:0] IMM_J    = IMM_W'(5);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic               valid;
    logic               mux1;
    logic               mux2;
    logic               mux3;
    logic               registerwrite;
    logic               memorywrite;
    logic               memoryread;
    logic               branch;
    logic               jump;
    logic               jal;
    logic               twoscomp;
    logic [ALUOP_W-1:0] aluop;
    logic [IMM_W-1:0]   immediate;
    logic               muldiv_start;
    logic               illegal;
  } id_ex_t;

  // funct3 -> ALU op for the base register/immediate arithmetic group
  function automatic logic [ALUOP_W-1:0] alu_base(input logic [2:0] funct3);
    case (funct3)
      3'd0:    alu_base = ALU_ADD;
      3'd1:    alu_base = ALU_SLL;
      3'd2:    alu_base = ALU_SLT;
      3'd3:    alu_base = ALU_SLTU;
      3'd4:    alu_base = ALU_XOR;
      3'd5:    alu_base = ALU_SRL;
      3'd6:    alu_base = ALU_OR;
      default: alu_base = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_control_stage_if.sv
// IF/ID-to-EX handshake of the decode stage: instruction in, stall/flush, control bundle out.
interface id_control_stage_if;
  import id_control_stage_pkg::*;

  logic [31:0] instruction;
  logic        valid_in;
  logic        stall_in;
  logic        flush;
  logic        stall_out;
  id_ex_t      idex;

  modport master (
    output instruction, valid_in, stall_in, flush,
    input  stall_out, idex
  );

  modport slave (
    input  instruction, valid_in, stall_in, flush,
    output stall_out, idex
  );
endinterface

// File: rtl/id_control_stage_decoder.sv
// Combinational RV32IM decoder: instruction -> control bundle, M-op class, illegal flag.
module id_control_stage_decoder import id_control_stage_pkg::*; #(
  parameter int unsigned ENABLE_M = 1
) (
  input  logic [31:0] instruction,
  output id_ex_t      ctrl_c,
  output logic        is_mul_c,
  output logic        is_div_c
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       illegal;
  logic       unused_fields;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];
  // register indices and immediate bits are consumed by the register file / EX
  assign unused_fields = ^instruction[24:7];

  always_comb begin
    ctrl_c       = '0;
    ctrl_c.valid = 1'b1;
    is_mul_c     = 1'b0;
    is_div_c     = 1'b0;
    illegal      = 1'b0;

    case (opcode)
      OPC_LUI: begin
        ctrl_c.registerwrite = 1'b1;
        ctrl_c.mux2          = 1'b1;
        ctrl_c.immediate     = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl_c.registerwrite = 1'b1;
        ctrl_c.mux1          = 1'b1;
        ctrl_c.mux2          = 1'b1;
        ctrl_c.immediate     = IMM_U;
      end
      OPC_JAL: begin
        ctrl_c.registerwrite = 1'b1;
        ctrl_c.jump          = 1'b1;
        ctrl_c.jal           = 1'b1;
        ctrl_c.mux1          = 1'b1;
        ctrl_c.immediate     = IMM_J;
      end
      OPC_JALR: begin
        ctrl_c.registerwrite = 1'b1;
        ctrl_c.jump          = 1'b1;
        ctrl_c.mux2          = 1'b1;
        ctrl_c.immediate     = IMM_I;
        illegal              = (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        ctrl_c.branch    = 1'b1;
        ctrl_c.twoscomp  = 1'b1;
        ctrl_c.immediate = IMM_B;
        case (funct3)
          3'd0, 3'd1: ctrl_c.aluop = ALU_SUB;
          3'd4, 3'd5: ctrl_c.aluop = ALU_SLT;
          3'd6, 3'd7: ctrl_c.aluop = ALU_SLTU;
          default:    illegal      = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ctrl_c.registerwrite = 1'b1;
        ctrl_c.memoryread    = 1'b1;
        ctrl_c.mux2          = 1'b1;
        ctrl_c.mux3          = 1'b1;
        ctrl_c.immediate     = IMM_I;
        illegal              = (funct3 == 3'd3) || (funct3 > 3'd5);
      end
      OPC_STORE: begin
        ctrl_c.memorywrite = 1'b1;
        ctrl_c.mux2        = 1'b1;
        ctrl_c.immediate   = IMM_S;
        illegal            = (funct3 > 3'd2);
      end
      OPC_OPIMM: begin
        ctrl_c.registerwrite = 1'b1;
        ctrl_c.mux2          = 1'b1;
        ctrl_c.immediate     = IMM_I;
        ctrl_c.aluop         = alu_base(funct3);
        ctrl_c.twoscomp      = (funct3 == 3'd2) || (funct3 == 3'd3);
        if (funct3 == 3'd1) begin
          illegal = (funct7 != F7_BASE);
        end else if (funct3 == 3'd5) begin
          if (funct7 == F7_ALT) ctrl_c.aluop = ALU_SRA;
          else illegal = (funct7 != F7_BASE);
        end
      end
      OPC_OP: begin
        ctrl_c.registerwrite = 1'b1;
        if (funct7 == F7_BASE) begin
          ctrl_c.aluop    = alu_base(funct3);
          ctrl_c.twoscomp = (funct3 == 3'd2) || (funct3 == 3'd3);
        end else if (funct7 == F7_ALT && funct3 == 3'd0) begin
          ctrl_c.aluop    = ALU_SUB;
          ctrl_c.twoscomp = 1'b1;
        end else if (funct7 == F7_ALT && funct3 == 3'd5) begin
          ctrl_c.aluop = ALU_SRA;
        end else if (funct7 == F7_MULDIV && ENABLE_M != 0) begin
          // M-extension codes are contiguous in funct3 order starting at MUL
          ctrl_c.aluop = ALU_MUL + ALUOP_W'(funct3);
          is_div_c     = funct3[2];
          is_mul_c     = ~funct3[2];
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      ctrl_c         = '0;
      ctrl_c.valid   = 1'b1;
      ctrl_c.illegal = 1'b1;
      is_mul_c       = 1'b0;
      is_div_c       = 1'b0;
    end
  end

endmodule

// File: rtl/id_control_stage.sv
// ID/EX register with stall/flush handling and the multi-cycle MUL/DIV occupancy sequencer.
module id_control_stage import id_control_stage_pkg::*; #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 8,
  parameter int unsigned ENABLE_M   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  id_control_stage_if.slave  bus
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  id_ex_t           out_q, out_d;
  id_ex_t           dec_c;
  logic             is_mul_c;
  logic             is_div_c;

  id_control_stage_decoder #(
    .ENABLE_M (ENABLE_M)
  ) u_decoder (
    .instruction (bus.instruction),
    .ctrl_c      (dec_c),
    .is_mul_c    (is_mul_c),
    .is_div_c    (is_div_c)
  );

  // Next state / next ID/EX entry: flush > stall > wait drain > accept
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;

    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      out_d   = '0;
    end else if (bus.stall_in) begin
      // entry is held, but the start pulse must not repeat
      out_d.muldiv_start = 1'b0;
    end else if (state_q == ST_WAIT) begin
      out_d = '0;
      if (cnt_q <= CNT_W'(1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      out_d = '0;
      if (bus.valid_in) begin
        out_d = dec_c;
        if (is_mul_c || is_div_c) begin
          out_d.muldiv_start = 1'b1;
          cnt_d              = is_mul_c ? MUL_LOAD : DIV_LOAD;
          if (cnt_d != '0) state_d = ST_WAIT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign bus.idex      = out_q;
  assign bus.stall_out = (state_q == ST_WAIT) || bus.stall_in;

endmodule
